cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Parametrised common-data-bus arbiter for the Tomasulo core.
// - Collects results from NUM_FU functional units (ALU and branch reservation stations) into one-entry result buffers.
// - Broadcasts up to NUM_BUS results per cycle on registered CDB lanes, with round-robin fairness.
// - Drives the ROB set-valid vector.
// - Adds backpressure, multi-lane broadcast, flush and duplicate-tag detection to the fixed 8-entry CDB.
// PARAMETERS
// NUM_FU   5   number of result producers (reservation station + ALU pairs)
// NUM_BUS  2   broadcast lanes per cycle, 1..NUM_FU
// TAG_W    3   ROB tag width; ROB depth = 2**TAG_W
// XLEN     32  result data width
// PORTS
// clk           in   1              clock, rising edge
// rst           in   1              reset: asynchronous, active-high
// flush         in   1              branch-mispredict flush; synchronous
// fu_valid      in   NUM_FU         producer i presents a result
// fu_ready      out  NUM_FU         result buffer i accepts this cycle
// fu_tag        in   NUM_FU*TAG_W   ROB tag for producer i, slice [i*TAG_W +: TAG_W]
// fu_data       in   NUM_FU*XLEN    result for producer i, slice [i*XLEN +: XLEN]
// cdb_valid     out  NUM_BUS        lane k broadcasting
// cdb_tag       out  NUM_BUS*TAG_W  lane k tag
// cdb_data      out  NUM_BUS*XLEN   lane k data
// rob_set_valid out  2**TAG_W       OR of one-hot(cdb_tag[k]) over valid lanes
// err_dup_tag   out  1              sticky: two lanes broadcast the same tag in one cycle
// BEHAVIOUR
// - Reset (async):
//   - clears all buf_valid, cdb_valid, rob_set_valid and err_dup_tag; zeroes cdb_tag and cdb_data.
//   - rr_ptr <= 0.
//   - An in-flight handshake is dropped.
// - Handshake:
//   - Transfer happens at a rising edge when fu_valid[i] & fu_ready[i].
//   - fu_ready[i] = ~flush & (~buf_valid[i] | grant[i]). It never depends on fu_valid.
//   - fu_tag and fu_data must stay stable while fu_valid is high and fu_ready is low.
// - Arbitration (combinational, over the buffer state):
//   - Scan channels rr_ptr, rr_ptr+1, ... mod NUM_FU.
//   - The first NUM_BUS channels with buf_valid set are granted.
//   - The j-th granted channel in scan order drives lane j. Unused lanes are invalid.
// - Broadcast registers (edge):
//   - cdb_valid[j] <= lane j used.
//   - Lane j tag and data <= that channel's buffered tag and data.
//   - rob_set_valid is registered in the same cycle as cdb_valid.
//   - Each granted buffer clears, unless it is reloaded by a same-edge handshake. In that case buf_valid stays 1 with the new contents.
// - Latency: a result accepted at edge E is on the CDB during the cycle after edge E+1 at the earliest (2 edges). It is later under contention.
// - rr_ptr update:
//   - Moves to (last granted channel + 1) mod NUM_FU.
//   - Unchanged when nothing is granted.
// - Starvation bound: a buffered result is granted within ceil(NUM_FU/NUM_BUS) cycles.
// - Flush (cycle-synchronous, flush high at edge F):
//   - All buf_valid clear.
//   - cdb_valid and rob_set_valid <= 0.
//   - rr_ptr <= 0.
//   - No transfer occurs, because fu_ready is 0 throughout the flush cycle.
//   - err_dup_tag is kept.
// - Duplicate tags:
//   - If two lanes granted in the same cycle carry the same tag, both broadcasts still occur.
//   - err_dup_tag is set at that edge and stays set until reset.
// - Idle: no buf_valid set -> all cdb_valid are 0 next cycle, data outputs hold their last value.
// - Widths: no arithmetic on data. rr_ptr is $clog2(NUM_FU) bits and wraps with an explicit modulo when NUM_FU is not a power of 2.
// - NUM_BUS == NUM_FU: every buffered result is granted every cycle, and fu_ready is 1 whenever flush is 0.
// TESTING
// - Reset mid-operation: fill buffers 0..4, assert rst asynchronously between edges -> outputs zero immediately, fu_ready = 5'b11111 once rst drops.
// - Single result, default params:
//   - stimulus: fu0 tag=3 data=0x600D600D, accepted at edge E.
//   - response: cdb_valid=2'b01, cdb_tag lane0=3, rob_set_valid=8'h08 after edge E+1.
//   - response: fu_ready[0] stays 1.
// - Round robin:
//   - stimulus: all 5 channels valid every cycle, rr_ptr=0.
//   - response: grants {0,1}, then {2,3}, then {4,0}.
//   - response: no channel waits more than 3 cycles; fu_ready is low only on non-granted full buffers.
// - Backpressure: NUM_BUS=1, channels 1 and 2 loaded at the same edge -> channel 1 broadcast first, fu_ready[2]=0 for that cycle, channel 2 broadcast next cycle with data intact.
// - Flush: buffers 0 and 3 full with fu_valid[1] high, pulse flush -> fu_ready=0 in that cycle, next cycle cdb_valid=0, rob_set_valid=0, no stale broadcast afterwards.
// - Duplicate tag: fu1 and fu4 both tag=5 granted together -> rob_set_valid=8'h20, both lanes valid, err_dup_tag=1 until rst.

Source files
------------

// File: rtl/cdb_if.sv
// cdb_if: producer-side handshake and CDB broadcast bundle for cdb_arbiter.
interface cdb_if #(parameter int NUM_FU = 5, NUM_BUS = 2, TAG_W = 3, XLEN = 32);
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*XLEN-1:0]   fu_data;
  logic [NUM_BUS-1:0]       cdb_valid;
  logic [NUM_BUS*TAG_W-1:0] cdb_tag;
  logic [NUM_BUS*XLEN-1:0]  cdb_data;
  logic [2**TAG_W-1:0]      rob_set_valid;
  logic                     err_dup_tag;
  modport master (output fu_valid, fu_tag, fu_data,
                  input fu_ready, cdb_valid, cdb_tag, cdb_data, rob_set_valid, err_dup_tag);
  modport slave (input fu_valid, fu_tag, fu_data,
                 output fu_ready, cdb_valid, cdb_tag, cdb_data, rob_set_valid, err_dup_tag);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one result per producer and broadcasts up to NUM_BUS per cycle, round-robin.
module cdb_arbiter #(parameter int NUM_FU = 5, NUM_BUS = 2, TAG_W = 3, XLEN = 32) (
  input logic clk,
  input logic rst,
  input logic flush,
  cdb_if.slave bus
);
  localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
  logic [NUM_FU-1:0] buf_valid, grant, fu_ready;
  logic [NUM_FU-1:0][TAG_W-1:0] buf_tag;
  logic [NUM_FU-1:0][XLEN-1:0] buf_data;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [NUM_BUS-1:0] lane_use, cdb_valid;
  logic [NUM_BUS-1:0][TAG_W-1:0] cdb_tag, nxt_tag;
  logic [NUM_BUS-1:0][XLEN-1:0] cdb_data, nxt_data;
  logic [2**TAG_W-1:0] rob_set_valid, nxt_rob;
  logic err_dup_tag, dup;
  int cnt, last;
  // Scan from rr_ptr; the cnt-th full buffer found drives lane cnt.
  always_comb begin
    grant = '0;
    lane_use = '0;
    nxt_tag = cdb_tag;
    nxt_data = cdb_data;
    nxt_rob = '0;
    dup = 1'b0;
    cnt = 0;
    last = 0;
    for (int k = 0; k < NUM_FU; k++)
      for (int i = 0; i < NUM_FU; i++)
        if (i == (int'(rr_ptr) + k) % NUM_FU && buf_valid[i] && cnt < NUM_BUS) begin
          grant[i] = 1'b1;
          for (int j = 0; j < NUM_BUS; j++)
            if (j == cnt) begin
              lane_use[j] = 1'b1;
              nxt_tag[j] = buf_tag[i];
              nxt_data[j] = buf_data[i];
            end
          cnt++;
          last = i;
        end
    for (int j = 0; j < NUM_BUS; j++)
      if (lane_use[j]) nxt_rob[nxt_tag[j]] = 1'b1;
    for (int j = 0; j < NUM_BUS; j++)
      for (int k = j + 1; k < NUM_BUS; k++)
        if (lane_use[j] && lane_use[k] && nxt_tag[j] == nxt_tag[k]) dup = 1'b1;
    rr_nxt = last == NUM_FU - 1 ? '0 : PW'(last + 1);
  end
  assign fu_ready = {NUM_FU{~flush}} & (~buf_valid | grant);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= '0;
      buf_tag <= '0;
      buf_data <= '0;
      rr_ptr <= '0;
      cdb_valid <= '0;
      cdb_tag <= '0;
      cdb_data <= '0;
      rob_set_valid <= '0;
      err_dup_tag <= 1'b0;
    end else if (flush) begin
      buf_valid <= '0;
      rr_ptr <= '0;
      cdb_valid <= '0;
      rob_set_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++)
        if (bus.fu_valid[i] && fu_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i] <= bus.fu_tag[i*TAG_W +: TAG_W];
          buf_data[i] <= bus.fu_data[i*XLEN +: XLEN];
        end else if (grant[i]) buf_valid[i] <= 1'b0;
      cdb_valid <= lane_use;
      cdb_tag <= nxt_tag;
      cdb_data <= nxt_data;
      rob_set_valid <= nxt_rob;
      if (|grant) rr_ptr <= rr_nxt;
      if (dup) err_dup_tag <= 1'b1;
    end
  end
  assign bus.fu_ready = fu_ready;
  assign bus.cdb_valid = cdb_valid;
  assign bus.cdb_tag = cdb_tag;
  assign bus.cdb_data = cdb_data;
  assign bus.rob_set_valid = rob_set_valid;
  assign bus.err_dup_tag = err_dup_tag;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  cdb_if b ();
  cdb_if #(.NUM_BUS(1)) b1 ();
  cdb_arbiter dut (.clk(clk), .rst(rst), .flush(flush), .bus(b));
  cdb_arbiter #(.NUM_BUS(1)) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1));
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  bit mv[5];
  logic [2:0] mt[5];
  logic [31:0] md[5];
  int mrr;
  int gl[$];
  logic [1:0] ecv;
  logic [5:0] ect;
  logic [63:0] ecd;
  logic [7:0] erob;
  logic eerr;
  logic [4:0] eready;
  logic [4:0] pend;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    mrr = 0;
    ecv = '0;
    ect = '0;
    ecd = '0;
    erob = '0;
    eerr = 1'b0;
  endtask
  // Grants: first two full buffers in circular order starting at mrr.
  task automatic model_comb();
    gl.delete();
    for (int k = 0; k < 5; k++) begin
      int c = (mrr + k) % 5;
      if (mv[c] && gl.size() < 2) gl.push_back(c);
    end
    for (int i = 0; i < 5; i++) begin
      bit g = 1'b0;
      foreach (gl[j]) if (gl[j] == i) g = 1'b1;
      eready[i] = !flush && (!mv[i] || g);
    end
  endtask
  task automatic model_update();
    if (flush) begin
      foreach (mv[i]) mv[i] = 1'b0;
      mrr = 0;
      ecv = '0;
      erob = '0;
      return;
    end
    ecv = '0;
    erob = '0;
    foreach (gl[j]) begin
      ecv[j] = 1'b1;
      ect[j*3 +: 3] = mt[gl[j]];
      ecd[j*32 +: 32] = md[gl[j]];
      erob[mt[gl[j]]] = 1'b1;
    end
    if (gl.size() == 2 && mt[gl[0]] == mt[gl[1]]) eerr = 1'b1;
    if (gl.size() > 0) mrr = (gl[gl.size()-1] + 1) % 5;
    foreach (gl[j]) mv[gl[j]] = 1'b0;
    for (int i = 0; i < 5; i++)
      if (b.fu_valid[i] && eready[i]) begin
        mv[i] = 1'b1;
        mt[i] = b.fu_tag[i*3 +: 3];
        md[i] = b.fu_data[i*32 +: 32];
      end
  endtask
  task automatic check_outs();
    chk("cdb_valid", 64'(b.cdb_valid), 64'(ecv));
    chk("cdb_tag", 64'(b.cdb_tag), 64'(ect));
    chk("cdb_data", b.cdb_data, ecd);
    chk("rob_set_valid", 64'(b.rob_set_valid), 64'(erob));
    chk("err_dup_tag", 64'(b.err_dup_tag), 64'(eerr));
  endtask
  // Inputs are driven just after a rising edge; ready is sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    chk("fu_ready", 64'(b.fu_ready), 64'(eready));
    @(posedge clk);
    model_update();
    #1;
    check_outs();
  endtask
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 model_reset();
    check_outs();
    rst = 1'b0;
    #1 chk("rst_ready", 64'(b.fu_ready), 64'h1F);
  endtask
  initial begin
    model_reset();
    b.fu_valid = '0; b.fu_tag = '0; b.fu_data = '0;
    b1.fu_valid = '0; b1.fu_tag = '0; b1.fu_data = '0;
    #2 check_outs();
    chk("reset_ready", 64'(b.fu_ready), 64'h1F);
    @(posedge clk);
    #1 rst = 1'b0;
    b.fu_valid = 5'b00001;
    b.fu_tag[2:0] = 3'd3;
    b.fu_data[31:0] = 32'h600D600D;
    tick();
    b.fu_valid = '0;
    tick();
    chk("single_valid", 64'(b.cdb_valid), 64'h1);
    chk("single_tag", 64'(b.cdb_tag[2:0]), 64'h3);
    chk("single_data", 64'(b.cdb_data[31:0]), 64'h600D600D);
    chk("single_rob", 64'(b.rob_set_valid), 64'h08);
    chk("single_ready", 64'(b.fu_ready[0]), 64'h1);
    tick();
    chk("idle_hold", 64'(b.cdb_data[31:0]), 64'h600D600D);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b.fu_tag[i*3 +: 3] = 3'(i);
      b.fu_data[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
    end
    b.fu_valid = 5'h1F;
    tick();
    tick();
    chk("rr_01", 64'(b.cdb_tag), 64'b001_000);
    chk("rr_ready", 64'(b.fu_ready), 64'b01100);
    tick();
    chk("rr_23", 64'(b.cdb_tag), 64'b011_010);
    tick();
    chk("rr_40", 64'(b.cdb_tag), 64'b000_100);
    chk("rr_valid", 64'(b.cdb_valid), 64'h3);
    do_reset();
    b.fu_valid = 5'b01001;
    b.fu_tag[2:0] = 3'd1;
    b.fu_tag[11:9] = 3'd2;
    tick();
    b.fu_valid = 5'b00010;
    flush = 1'b1;
    #1 chk("flush_ready", 64'(b.fu_ready), 64'h0);
    tick();
    chk("flush_valid", 64'(b.cdb_valid), 64'h0);
    chk("flush_rob", 64'(b.rob_set_valid), 64'h0);
    flush = 1'b0;
    b.fu_valid = '0;
    tick();
    chk("flush_stale", 64'(b.cdb_valid), 64'h0);
    b.fu_tag[5:3] = 3'd5;
    b.fu_tag[14:12] = 3'd5;
    b.fu_data[63:32] = 32'h11111111;
    b.fu_data[159:128] = 32'h44444444;
    b.fu_valid = 5'b10010;
    tick();
    b.fu_valid = '0;
    tick();
    chk("dup_rob", 64'(b.rob_set_valid), 64'h20);
    chk("dup_valid", 64'(b.cdb_valid), 64'h3);
    chk("dup_err", 64'(b.err_dup_tag), 64'h1);
    tick();
    chk("dup_sticky", 64'(b.err_dup_tag), 64'h1);
    b1.fu_valid = 5'b00110;
    b1.fu_tag[5:3] = 3'd6;
    b1.fu_tag[8:6] = 3'd2;
    b1.fu_data[63:32] = 32'hAAAA5555;
    b1.fu_data[95:64] = 32'hBBBB6666;
    tick();
    b1.fu_valid = '0;
    chk("bp_ready", 64'(b1.fu_ready[2:1]), 64'b01);
    tick();
    chk("bp_first_valid", 64'(b1.cdb_valid), 64'h1);
    chk("bp_first_tag", 64'(b1.cdb_tag), 64'h6);
    chk("bp_first_data", 64'(b1.cdb_data), 64'hAAAA5555);
    tick();
    chk("bp_second_tag", 64'(b1.cdb_tag), 64'h2);
    chk("bp_second_data", 64'(b1.cdb_data), 64'hBBBB6666);
    chk("bp_second_rob", 64'(b1.rob_set_valid), 64'h04);
    do_reset();
    pend = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 5; i++)
        if (!pend[i]) begin
          b.fu_valid[i] = 1'($urandom_range(0, 1));
          b.fu_tag[i*3 +: 3] = 3'($urandom);
          b.fu_data[i*32 +: 32] = $urandom;
        end
      flush = ($urandom_range(0, 15) == 0);
      tick();
      pend = b.fu_valid & ~eready;
    end
    flush = 1'b0;
    b.fu_valid = '0;
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
